// File: rtl/calc_core.sv
// calc_core: accumulator datapath core (PC, IR, X/Y/Z, ALU) with a start/busy/done handshake.
// Define CALC_CORE_FLAGS_EN to add the zero/carry flags, their outputs and the JZ instruction.
module calc_core #(
  parameter int WIDTH = 4,
  parameter int PC_W  = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic [PC_W-1:0]  instr_addr,
  input  logic [WIDTH+3:0] instr_data,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] z_out,
  output logic             z_valid
`ifdef CALC_CORE_FLAGS_EN
  ,
  output logic             zf_out,
  output logic             cf_out
`endif
);

  // state | meaning
  // IDLE  | waiting for start; PC, X, Y, Z hold
  // FETCH | IR <= instr_data, PC <= PC+1
  // EXEC  | execute IR; HALT -> DONE, otherwise -> FETCH
  // DONE  | one-cycle completion pulse, then IDLE
  typedef enum logic [1:0] {IDLE, FETCH, EXEC, DONE} stateT;

  typedef enum logic [3:0] {
    OP_NOP = 4'h0, OP_LDX, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_CLRY,
    OP_MOVZ, OP_SHRY, OP_JMP, OP_JZ, OP_RSV_C, OP_RSV_D, OP_RSV_E, OP_HALT
  } opcodeT;

  stateT            state;
  logic [PC_W-1:0]  pc;
  logic [WIDTH+3:0] ir;
  logic [WIDTH-1:0] regX, regY, regZ;

  opcodeT           op;
  logic [WIDTH-1:0] imm;
  logic [PC_W-1:0]  immPc;

  assign op    = opcodeT'(ir[WIDTH+3:WIDTH]);
  assign imm   = ir[WIDTH-1:0];
  assign immPc = PC_W'(imm);

  assign instr_addr = pc;
  assign z_out      = regZ;

`ifdef CALC_CORE_FLAGS_EN
  logic zf, cf;
`endif

  // One-hot register transfer controls; at most one destination changes per instruction.
  logic             ldX, ldY, clrY, ldZ, ldPc;
  logic [WIDTH-1:0] aluY;

  always_comb begin
    ldX  = 1'b0;
    ldY  = 1'b0;
    clrY = 1'b0;
    ldZ  = 1'b0;
    ldPc = 1'b0;
    aluY = regY;
    if (state == EXEC) begin
      case (op)
        OP_LDX:  ldX = 1'b1;
        OP_ADD:  begin ldY = 1'b1; aluY = regY + regX; end
        OP_SUB:  begin ldY = 1'b1; aluY = regY - regX; end
        OP_AND:  begin ldY = 1'b1; aluY = regY & regX; end
        OP_OR:   begin ldY = 1'b1; aluY = regY | regX; end
        OP_XOR:  begin ldY = 1'b1; aluY = regY ^ regX; end
        OP_SHRY: begin ldY = 1'b1; aluY = regY >> 1; end
        OP_CLRY: clrY = 1'b1;
        OP_MOVZ: ldZ  = 1'b1;
        OP_JMP:  ldPc = 1'b1;
`ifdef CALC_CORE_FLAGS_EN
        OP_JZ:   ldPc = zf;
`endif
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      pc      <= '0;
      ir      <= '0;
      regX    <= '0;
      regY    <= '0;
      regZ    <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      z_valid <= 1'b0;
    end else begin
      done    <= 1'b0;
      z_valid <= ldZ;
      unique case (state)
        IDLE: begin
          if (start) begin
            pc    <= '0;
            regX  <= '0;
            regY  <= '0;
            busy  <= 1'b1;
            state <= FETCH;
          end
        end
        FETCH: begin
          ir    <= instr_data;
          pc    <= pc + PC_W'(1);
          state <= EXEC;
        end
        EXEC: begin
          if (ldX) regX <= imm;
          if (ldY) regY <= aluY;
          else if (clrY) regY <= '0;
          if (ldZ) regZ <= regY;
          // A taken jump replaces the increment already applied in FETCH.
          if (ldPc) pc <= immPc;
          if (op == OP_HALT) begin
            done  <= 1'b1;
            state <= DONE;
          end else begin
            state <= FETCH;
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef CALC_CORE_FLAGS_EN
  logic updZf, updCf;

  assign updZf = ldY | clrY;
  assign updCf = (state == EXEC) && ((op == OP_ADD) || (op == OP_SUB));

  // Unsigned carry of an add shows up as a result smaller than an operand.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      zf <= 1'b0;
      cf <= 1'b0;
    end else if ((state == IDLE) && start) begin
      zf <= 1'b0;
      cf <= 1'b0;
    end else begin
      if (updZf) zf <= clrY | (aluY == '0);
      if (updCf) cf <= (op == OP_SUB) ? (regY < regX) : (aluY < regY);
    end
  end

  assign zf_out = zf;
  assign cf_out = cf;
`endif

endmodule

// File: tb/tb_calc_core.sv
// Directed-vector bench for calc_core: small programs with hand-computed results and timing.
// Flag checks are compiled in when CALC_CORE_FLAGS_EN is defined.
`timescale 1ns/1ps
module tb_calc_core;
  localparam int WIDTH = 4;
  localparam int PC_W  = 4;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic [PC_W-1:0]  instr_addr;
  logic [WIDTH+3:0] instr_data;
  logic             busy, done, z_valid;
  logic [WIDTH-1:0] z_out;
`ifdef CALC_CORE_FLAGS_EN
  logic             zf_out, cf_out;
`endif

  logic [WIDTH+3:0] mem [16];
  assign instr_data = mem[instr_addr];

  int checks = 0;
  int errors = 0;

  logic [WIDTH-1:0] zVals [8];
  int zCnt, doneAt;
  bit sawDone;

  always #5 clk = ~clk;

  calc_core #(.WIDTH(WIDTH), .PC_W(PC_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .instr_addr (instr_addr),
    .instr_data (instr_data),
    .busy       (busy),
    .done       (done),
    .z_out      (z_out),
    .z_valid    (z_valid)
`ifdef CALC_CORE_FLAGS_EN
    ,
    .zf_out     (zf_out),
    .cf_out     (cf_out)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clearMem();
    for (int i = 0; i < 16; i++) mem[i] = 8'hF0;
  endtask

  // Launch a program and watch it until done or the cycle budget runs out.
  // doneAt counts clock edges after the one that accepted start.
  task automatic runProg(input int holdCycles, input bit swapAtF, input int maxCycles);
    int n;
    bit busyLow;
    zCnt = 0; doneAt = -1; n = 0; busyLow = 0;
    @(negedge clk); start = 1'b1;
    @(posedge clk); #1;
    if (holdCycles == 0) start = 1'b0;
    check("busy_rise", busy, 1);
    while (n < maxCycles && doneAt < 0) begin
      @(posedge clk); #1; n++;
      if (z_valid && zCnt < 8) begin zVals[zCnt] = z_out; zCnt++; end
      if (done) doneAt = n;
      if (!busy) busyLow = 1;
      if (swapAtF && instr_addr == 4'hF) mem[0] = 8'hF0;
      if (n == holdCycles) start = 1'b0;
    end
    start = 1'b0;
    check("busy_held", busyLow, 0);
    @(posedge clk); #1;
    check("done_one_cycle", done, 0);
    check("busy_fall", busy, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    clearMem();
    // Reset and idle
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_addr", instr_addr, 0);
    @(negedge clk); rst_n = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    check("idle_addr", instr_addr, 0);
    check("idle_z", z_out, 0);
    check("idle_busy", busy, 0);
    check("idle_done", done, 0);
    check("idle_zvalid", z_valid, 0);
`ifdef CALC_CORE_FLAGS_EN
    check("idle_zf", zf_out, 0);
    check("idle_cf", cf_out, 0);
`endif

    // Basic: LDX 3; ADD; LDX 5; ADD; MOVZ; HALT
    clearMem();
    mem[0] = 8'h13; mem[1] = 8'h20; mem[2] = 8'h15; mem[3] = 8'h20; mem[4] = 8'h80; mem[5] = 8'hF0;
    runProg(0, 0, 40);
    check("basic_done_at", doneAt, 12);
    check("basic_zcnt", zCnt, 1);
    check("basic_z", zVals[0], 8);
    check("basic_pc_end", instr_addr, 6);

    // Start held high during busy must be ignored
    runProg(6, 0, 40);
    check("hold_done_at", doneAt, 12);
    check("hold_zcnt", zCnt, 1);
    check("hold_z", zVals[0], 8);

    // Logic ops: LDX 6; ADD; LDX 3; AND; MOVZ; LDX 9; OR; MOVZ; LDX 5; XOR; SHRY; MOVZ; HALT
    clearMem();
    mem[0] = 8'h16; mem[1] = 8'h20; mem[2] = 8'h13; mem[3] = 8'h40; mem[4] = 8'h80;
    mem[5] = 8'h19; mem[6] = 8'h50; mem[7] = 8'h80; mem[8] = 8'h15; mem[9] = 8'h60;
    mem[10] = 8'h90; mem[11] = 8'h80; mem[12] = 8'hF0;
    runProg(0, 0, 60);
    check("logic_done_at", doneAt, 26);
    check("logic_zcnt", zCnt, 3);
    check("logic_and", zVals[0], 4'h2);
    check("logic_or", zVals[1], 4'hB);
    check("logic_xor_shr", zVals[2], 4'h7);

    // Reserved ops and CLRY: LDX 5; ADD; C; D; E; NOP; MOVZ; CLRY; MOVZ; HALT
    clearMem();
    mem[0] = 8'h15; mem[1] = 8'h20; mem[2] = 8'hC3; mem[3] = 8'hD7; mem[4] = 8'hE1;
    mem[5] = 8'h00; mem[6] = 8'h80; mem[7] = 8'h70; mem[8] = 8'h80; mem[9] = 8'hF0;
    runProg(0, 0, 60);
    check("rsv_done_at", doneAt, 20);
    check("rsv_zcnt", zCnt, 2);
    check("rsv_z", zVals[0], 4'h5);
    check("clry_z", zVals[1], 4'h0);

    // Jump: LDX 2; ADD; JMP 5; ADD; HALT; MOVZ; HALT
    clearMem();
    mem[0] = 8'h12; mem[1] = 8'h20; mem[2] = 8'hA5; mem[3] = 8'h20; mem[4] = 8'hF0;
    mem[5] = 8'h80; mem[6] = 8'hF0;
    runProg(0, 0, 40);
    check("jmp_done_at", doneAt, 10);
    check("jmp_zcnt", zCnt, 1);
    check("jmp_z", zVals[0], 4'h2);
    check("jmp_pc_end", instr_addr, 7);

    // Opcode B after CLRY: JZ 5 taken only with flags
    clearMem();
    mem[0] = 8'h70; mem[1] = 8'hB5; mem[2] = 8'h13; mem[3] = 8'h20; mem[4] = 8'h80; mem[5] = 8'hF0;
    runProg(0, 0, 40);
`ifdef CALC_CORE_FLAGS_EN
    check("jz_done_at", doneAt, 6);
    check("jz_zcnt", zCnt, 0);
`else
    check("opb_done_at", doneAt, 12);
    check("opb_zcnt", zCnt, 1);
    check("opb_z", zVals[0], 4'h3);
`endif

    // PC walk with JMP 0 at F; HALT swapped into address 0 after the first pass
    clearMem();
    for (int i = 0; i < 15; i++) mem[i] = 8'h00;
    mem[15] = 8'hA0;
    runProg(0, 1, 80);
    check("jmpf_done_at", doneAt, 34);
    check("jmpf_pc_end", instr_addr, 1);

    // PC increment from F wraps to 0
    clearMem();
    for (int i = 0; i < 16; i++) mem[i] = 8'h00;
    runProg(0, 1, 80);
    check("wrap_done_at", doneAt, 34);
    check("wrap_pc_end", instr_addr, 1);

    // Wrap arithmetic: LDX F; ADD; ADD; MOVZ; SUB; MOVZ; HALT
    clearMem();
    mem[0] = 8'h1F; mem[1] = 8'h20; mem[2] = 8'h20; mem[3] = 8'h80; mem[4] = 8'h30; mem[5] = 8'h80; mem[6] = 8'hF0;
    runProg(0, 0, 40);
    check("arith_done_at", doneAt, 14);
    check("arith_zcnt", zCnt, 2);
    check("arith_add_wrap", zVals[0], 4'hE);
    check("arith_sub_wrap", zVals[1], 4'hF);

    // Reset mid-program: basic program aborted after 5 cycles
    clearMem();
    mem[0] = 8'h13; mem[1] = 8'h20; mem[2] = 8'h15; mem[3] = 8'h20; mem[4] = 8'h80; mem[5] = 8'hF0;
    @(negedge clk); start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    repeat (5) @(posedge clk);
    #2; rst_n = 1'b0;
    #1;
    check("abort_busy", busy, 0);
    check("abort_addr", instr_addr, 0);
    check("abort_z", z_out, 0);
    check("abort_done", done, 0);
    check("abort_zvalid", z_valid, 0);
    sawDone = 0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      if (done) sawDone = 1;
    end
    @(negedge clk); rst_n = 1'b1;
    for (int i = 0; i < 16; i++) begin
      @(posedge clk); #1;
      if (done) sawDone = 1;
    end
    check("abort_no_done", sawDone, 0);
    check("abort_idle", busy, 0);
    runProg(0, 0, 40);
    check("recover_done_at", doneAt, 12);
    check("recover_z", zVals[0], 8);

`ifdef CALC_CORE_FLAGS_EN
    // LDX 2; ADD; LDX 3; SUB; MOVZ; HALT -> Y=F, borrow
    clearMem();
    mem[0] = 8'h12; mem[1] = 8'h20; mem[2] = 8'h13; mem[3] = 8'h30; mem[4] = 8'h80; mem[5] = 8'hF0;
    runProg(0, 0, 40);
    check("flag_sub_z", zVals[0], 4'hF);
    check("flag_sub_cf", cf_out, 1);
    check("flag_sub_zf", zf_out, 0);

    // LDX 1; ADD; LDX 1; SUB; JZ 7 -> lands on MOVZ at 7
    clearMem();
    mem[0] = 8'h11; mem[1] = 8'h20; mem[2] = 8'h11; mem[3] = 8'h30; mem[4] = 8'hB7;
    mem[7] = 8'h80; mem[8] = 8'hF0;
    runProg(0, 0, 40);
    check("flag_jz_done_at", doneAt, 14);
    check("flag_jz_zcnt", zCnt, 1);
    check("flag_jz_zf", zf_out, 1);
    check("flag_jz_cf", cf_out, 0);
    check("flag_jz_pc_end", instr_addr, 9);

    // LDX F; ADD; LDX 1; ADD -> carry out, Y=0
    clearMem();
    mem[0] = 8'h1F; mem[1] = 8'h20; mem[2] = 8'h11; mem[3] = 8'h20; mem[4] = 8'hF0;
    runProg(0, 0, 40);
    check("flag_add_cf", cf_out, 1);
    check("flag_add_zf", zf_out, 1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/calc_core.md
Name: calc_core

Overview:
- Parametrised accumulator datapath core: program counter, instruction register, FSM control unit, registers X/Y/Z and an ALU.
- Runs a program from an external combinational instruction memory: address out, word in.
- Y is the accumulator. X holds the immediate operand. Z is the visible result register.
- A start/busy/done handshake lets a host launch a program and detect completion.

Parameters:
- WIDTH, 4, data width of X, Y, Z, the ALU and the immediate field.
- PC_W, 4, program counter width; program depth is 2^PC_W words.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  launch request; sampled only in IDLE.
- instr_addr  output  PC_W  instruction memory address (equals PC).
- instr_data  input  4+WIDTH  instruction word: [WIDTH+3:WIDTH] opcode, [WIDTH-1:0] immediate.
- busy  output  1  high from the cycle after start is accepted until DONE is left.
- done  output  1  one-cycle pulse in the DONE state.
- z_out  output  WIDTH  contents of register Z.
- z_valid  output  1  one-cycle pulse in the cycle after Z is loaded.

Behaviour:
- Reset (async, rst_n=0): state=IDLE; PC, IR, X, Y, Z = 0; busy, done, z_valid = 0. Reset mid-program aborts immediately, with no completion pulse.
- State IDLE: busy=0. On start=1: PC<=0, X<=0, Y<=0 (Z retained), go to FETCH.
- State FETCH: IR<=instr_data; PC<=PC+1 (mod 2^PC_W, so 2^PC_W-1 wraps to 0); go to EXEC.
- State EXEC: execute IR. Next state is DONE if the opcode is HALT, otherwise FETCH.
- Each instruction takes exactly 2 cycles.
- start asserted while busy=1 is ignored.
- State DONE: done=1 for one cycle, busy=1; go to IDLE.
- Opcodes (ALU results truncated mod 2^WIDTH):
  - 0 NOP: no change.
  - 1 LDX: X<=imm.
  - 2 ADD: Y<=Y+X.
  - 3 SUB: Y<=Y-X (two's complement wrap).
  - 4 AND: Y<=Y&X.
  - 5 OR: Y<=Y|X.
  - 6 XOR: Y<=Y^X.
  - 7 CLRY: Y<=0.
  - 8 MOVZ: Z<=Y; z_valid=1 the next cycle.
  - 9 SHRY: Y<=Y>>1, logical shift, MSB filled with 0.
  - A JMP: PC<=imm, zero-extended or truncated to PC_W; overrides the FETCH increment.
  - B JZ: see Optional Feature.
  - C,D,E reserved: executed as NOP.
  - F HALT.
- Register transfer control per register: hold / load / clear, one-hot decoded from the opcode in EXEC. Only one destination register changes per instruction.
- A JMP to its own address loops forever; the core stays busy until reset.
- instr_data is sampled only in FETCH; its value in other states is don't-care.

Optional Feature:
- Macro: CALC_CORE_FLAGS_EN.
- With the macro defined:
  - Adds outputs zf_out (1 bit) and cf_out (1 bit); both reset to 0 and are cleared on start.
  - zf is updated on ADD, SUB, AND, OR, XOR, SHRY and CLRY: zf = (new Y == 0).
  - cf is updated on ADD (carry out of the MSB) and SUB (1 = borrow, i.e. Y<X unsigned); other ops leave cf unchanged.
  - JZ: if zf=1 then PC<=imm, else fall through.
- Without the macro: no flag ports or flag logic; opcode B executes as NOP.

Test Plan (WIDTH=4, PC_W=4):
- Reset/idle: hold rst_n=0, then release with no start -> instr_addr=0, z_out=0, busy=0, done=0, z_valid=0 indefinitely.
- Basic program: LDX 3; ADD; LDX 5; ADD; MOVZ; HALT.
  - z_out=8 with a single z_valid pulse.
  - done pulses exactly 12 cycles after busy rises (6 instructions x 2).
- Wrap arithmetic: LDX F; ADD; ADD; MOVZ; HALT -> z_out=E. Then SUB with X=F from Y=E -> Y=F.
- Jump and PC wrap: HALT at address 0, JMP 0 at address F, NOPs at addresses 1..E, started with PC forced through F. Expected: JMP 0 at F reaches HALT at 0. Also check a PC increment from F lands at 0.
- Handshake: assert start during busy -> ignored, PC sequence unchanged. Assert rst_n=0 mid-program -> all outputs 0 immediately, no done pulse.
- FLAGS_EN:
  - LDX 1; ADD; LDX 1; SUB; JZ 7 -> zf=1, PC=7.
  - LDX 2; ADD (Y=2); LDX 3; SUB -> cf=1, Y=F.
  - Without the macro, opcode B acts as NOP.
